mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares one single-port memory between the instruction-fetch requester and the load/store requester
//  of the RISC-V core, so the instruction and data memories can be merged into one array.
//  Issues one transaction at a time, tracks the fixed memory read latency and routes each response
//  back to the requester that owns it. Sits between the core and the unified memory.
// PARAMETERS
//  ADDR_W   32  address width, both requesters and the memory
//  DATA_W   32  data width
//  MEM_LAT  2   memory read latency in cycles, legal range 1..4
// PORTS
//  iCLK      in   1       clock, all state updates on rising edge
//  iRST      in   1       reset, asynchronous, active-low
//  iIReq     in   1       instruction read request; hold until oIGnt
//  iIAddr    in   ADDR_W  instruction address
//  oIGnt     out  1       instruction request accepted this cycle
//  oIValid   out  1       oIData valid, one-cycle pulse
//  oIData    out  DATA_W  fetched instruction
//  iDReq     in   1       data request; hold until oDGnt
//  iDWe      in   1       1 = store, 0 = load
//  iDBe      in   4       store byte enables
//  iDAddr    in   ADDR_W  data address
//  iDWData   in   DATA_W  store data
//  oDGnt     out  1       data request accepted this cycle
//  oDValid   out  1       load data valid, or store acknowledge; one-cycle pulse
//  oDRData   out  DATA_W  load data
//  oMReq     out  1       memory access strobe, one cycle per transaction
//  oMWe      out  1       memory write enable
//  oMBe      out  4       memory byte enables
//  oMAddr    out  ADDR_W  memory address
//  oMWData   out  DATA_W  memory write data
//  iMRData   in   DATA_W  memory read data, valid MEM_LAT cycles after the oMReq cycle
//  oBusy     out  1       transaction in flight (state != IDLE)
// BEHAVIOUR
//  - Reset: state IDLE, latency counter 0, all outputs 0, RR pointer = "instruction served last";
//    any in-flight response is discarded.
//  - FSM IDLE -> WAIT -> RESP -> IDLE. Store: IDLE -> RESP.
//  - IDLE, any request: select a winner and assert its Gnt combinationally in the same cycle T.
//    In cycle T, oMReq=1 and oMAddr/oMWe/oMBe/oMWData are driven from the winner.
//    Instruction fetch: oMWe=0, oMBe=4'hF. No request: oMReq=0, all grants 0.
//  - Load/fetch: the counter runs during WAIT. iMRData is registered into the owner's data output
//    in cycle T+MEM_LAT. The owner's Valid is high in cycle T+MEM_LAT+1 (RESP).
//  - Store: memory writes on the edge ending T. oDValid=1 in cycle T+1 (RESP); oDRData unchanged.
//  - RESP behaves as IDLE for arbitration, so a new grant may coincide with the Valid pulse.
//    Read throughput: one access per MEM_LAT+1 cycles.
//  - Requests during WAIT get no grant. Requesters hold request and operands; a request dropped
//    before its grant is never issued.
//  - oIData/oDRData hold their last value between responses.
//  - Only the owner's Valid pulses; the other requester's outputs are unaffected.
//  - Counter width $clog2(MEM_LAT+1); it saturates at MEM_LAT, no wrap.
//  - Reset asserted mid-transaction: immediate return to IDLE, no Valid issued.
// CONFIGURATION
//  ARB_RR_EN defined: round-robin. On a simultaneous request, the requester not served last wins.
//    The pointer updates on every grant.
//  ARB_RR_EN undefined: fixed priority, data beats instruction on every tie. No pointer register.
// TESTING
//  1. MEM_LAT=2, fetch @0x00400000, memory returns 0x00500093
//     -> oIGnt at T, oMReq T only, oIValid at T+3, oIData=0x00500093
//  2. Store @0x10010000, data 0xDEADBEEF, iDBe=4'hF
//     -> oMWe=1 at T, oDValid at T+1, next load @0x10010000 returns 0xDEADBEEF
//  3. iIReq and iDReq together, held, 3 rounds
//     -> fixed priority: D,D,D while iDReq is held; ARB_RR_EN: D,I,D
//  4. Back-to-back fetches @0x0, @0x4
//     -> second oIGnt coincides with the first oIValid; grants 3 cycles apart
//  5. iRST low in the WAIT cycle of a load
//     -> all outputs 0 at once, no oDValid; a fresh request after release completes normally
//  6. iDReq raised during another requester's WAIT
//     -> no oDGnt until RESP; oMReq never high twice within one transaction

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one single-port memory between instruction fetch and load/store
// ARB_RR_EN selects round-robin arbitration; undefined gives fixed data-over-instruction priority.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iIReq,
  input  logic [ADDR_W-1:0] iIAddr,
  output logic              oIGnt,
  output logic              oIValid,
  output logic [DATA_W-1:0] oIData,
  input  logic              iDReq,
  input  logic              iDWe,
  input  logic [3:0]        iDBe,
  input  logic [ADDR_W-1:0] iDAddr,
  input  logic [DATA_W-1:0] iDWData,
  output logic              oDGnt,
  output logic              oDValid,
  output logic [DATA_W-1:0] oDRData,
  output logic              oMReq,
  output logic              oMWe,
  output logic [3:0]        oMBe,
  output logic [ADDR_W-1:0] oMAddr,
  output logic [DATA_W-1:0] oMWData,
  input  logic [DATA_W-1:0] iMRData,
  output logic              oBusy
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] LAT_MAX = CNT_W'(MEM_LAT);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} stateT;

  stateT            state;
  logic [CNT_W-1:0] latCnt;
  logic             ownerD;
  logic             canArb;
  logic             selD;
  logic             grantI;
  logic             grantD;

`ifdef ARB_RR_EN
  logic lastI;

  always_comb selD = iDReq && (!iIReq || lastI);

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST)
      lastI <= 1'b1;
    else if (grantI || grantD)
      lastI <= grantI;
  end
`else
  always_comb selD = iDReq;
`endif

  // RESP arbitrates like IDLE; gating with iRST keeps every output low while reset is held.
  assign canArb = iRST && (state != WAIT);
  assign grantD = canArb && selD;
  assign grantI = canArb && iIReq && !selD;
  assign oIGnt  = grantI;
  assign oDGnt  = grantD;
  assign oBusy  = (state != IDLE);

  always_comb begin
    oMReq   = grantI || grantD;
    oMWe    = grantD && iDWe;
    oMBe    = grantD ? iDBe : (grantI ? 4'hF : 4'h0);
    oMAddr  = grantD ? iDAddr : (grantI ? iIAddr : '0);
    oMWData = grantD ? iDWData : '0;
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state   <= IDLE;
      latCnt  <= '0;
      ownerD  <= 1'b0;
      oIValid <= 1'b0;
      oDValid <= 1'b0;
      oIData  <= '0;
      oDRData <= '0;
    end else begin
      oIValid <= 1'b0;
      oDValid <= 1'b0;
      case (state)
        WAIT: begin
          if (latCnt == LAT_MAX) begin
            state <= RESP;
            if (ownerD) begin
              oDRData <= iMRData;
              oDValid <= 1'b1;
            end else begin
              oIData  <= iMRData;
              oIValid <= 1'b1;
            end
          end else begin
            latCnt <= latCnt + CNT_W'(1);
          end
        end
        default: begin
          if (grantI || grantD) begin
            ownerD <= grantD;
            // A store completes on the grant edge, so it skips the latency wait.
            if (grantD && iDWe) begin
              state   <= RESP;
              oDValid <= 1'b1;
              latCnt  <= '0;
            end else begin
              state  <= WAIT;
              latCnt <= CNT_W'(1);
            end
          end else begin
            state  <= IDLE;
            latCnt <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed-vector bench for mem_arbiter with a latency-2 memory model
module tb_mem_arbiter;
  localparam int LAT = 2;

  logic        iCLK, iRST;
  logic        iIReq, iDReq, iDWe;
  logic [31:0] iIAddr, iDAddr, iDWData, iMRData;
  logic [3:0]  iDBe;
  logic        oIGnt, oIValid, oDGnt, oDValid, oMReq, oMWe, oBusy;
  logic [31:0] oIData, oDRData, oMAddr, oMWData;
  logic [3:0]  oMBe;

  int vecCount  = 0;
  int missCount = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
    .iCLK(iCLK), .iRST(iRST),
    .iIReq(iIReq), .iIAddr(iIAddr), .oIGnt(oIGnt), .oIValid(oIValid), .oIData(oIData),
    .iDReq(iDReq), .iDWe(iDWe), .iDBe(iDBe), .iDAddr(iDAddr), .iDWData(iDWData),
    .oDGnt(oDGnt), .oDValid(oDValid), .oDRData(oDRData),
    .oMReq(oMReq), .oMWe(oMWe), .oMBe(oMBe), .oMAddr(oMAddr), .oMWData(oMWData),
    .iMRData(iMRData), .oBusy(oBusy)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  // Word memory: writes land on the strobe edge, read data appears LAT cycles after the strobe.
  logic [31:0] mem [logic [31:0]];
  logic [31:0] pipe0, pipe1;
  assign iMRData = pipe1;

  always @(posedge iCLK) begin : memModel
    logic [31:0] wa, w, rd;
    wa = {oMAddr[31:2], 2'b00};
    rd = 32'hA5A5A5A5;
    if (oMReq) begin
      w = mem.exists(wa) ? mem[wa] : 32'h0;
      if (oMWe) begin
        for (int b = 0; b < 4; b++)
          if (oMBe[b]) w[8*b +: 8] = oMWData[8*b +: 8];
        mem[wa] = w;
      end else begin
        rd = w;
      end
    end
    pipe0 <= rd;
    pipe1 <= pipe0;
  end

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] want);
    vecCount++;
    if (got !== want) begin
      missCount++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic cyc;
    @(posedge iCLK);
    #1;
  endtask

  task automatic readTxn(input bit isD, input logic [31:0] addr, input logic [31:0] expData,
                         input string tag);
    bit got;
    cyc;
    if (isD) begin
      iDReq = 1'b1; iDWe = 1'b0; iDBe = 4'hF; iDAddr = addr;
    end else begin
      iIReq = 1'b1; iIAddr = addr;
    end
    got = 1'b0;
    for (int n = 0; n < 8 && !got; n++) begin
      @(negedge iCLK);
      got = isD ? oDGnt : oIGnt;
      if (!got) cyc;
    end
    checkVal({tag, " gnt"}, got, 1);
    checkVal({tag, " maddr"}, oMAddr, addr);
    checkVal({tag, " mwe/mbe"}, {oMReq, oMWe, oMBe}, {1'b1, 1'b0, 4'hF});
    cyc;
    iIReq = 1'b0; iDReq = 1'b0;
    for (int k = 1; k <= LAT + 1; k++) begin
      if (k > 1) cyc;
      @(negedge iCLK);
      checkVal({tag, " mreq once"}, oMReq, 0);
      checkVal({tag, " valid"}, isD ? oDValid : oIValid, (k == LAT + 1));
      checkVal({tag, " other valid"}, isD ? oIValid : oDValid, 0);
    end
    checkVal({tag, " data"}, isD ? oDRData : oIData, expData);
  endtask

  typedef enum logic {WIN_I, WIN_D} winT;
  winT winners [3];
  winT expWin  [3];
  int  rounds;
  bit  idle;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    mem[32'h00400000] = 32'h00500093;
    mem[32'h00000000] = 32'h00000013;
    mem[32'h00000004] = 32'h00100113;
    mem[32'h10010040] = 32'hCAFEF00D;
    iRST = 1'b0; iIReq = 1'b0; iDReq = 1'b0; iDWe = 1'b0; iDBe = 4'h0;
    iIAddr = '0; iDAddr = '0; iDWData = '0;

    // Reset state
    cyc; cyc;
    @(negedge iCLK);
    checkVal("reset ctrl", {oBusy, oIValid, oDValid, oMReq, oIGnt, oDGnt}, 0);
    checkVal("reset data", {oIData, oDRData}, 0);
    cyc;
    iRST = 1'b1;

    // Single fetch
    readTxn(1'b0, 32'h00400000, 32'h00500093, "fetch");
    cyc;
    @(negedge iCLK);
    checkVal("fetch hold", oIData, 32'h00500093);
    checkVal("fetch idle", {oBusy, oIValid}, 0);

    // Full store, then readback
    cyc;
    iDReq = 1'b1; iDWe = 1'b1; iDBe = 4'hF; iDAddr = 32'h10010000; iDWData = 32'hDEADBEEF;
    @(negedge iCLK);
    checkVal("st gnt", {oDGnt, oMReq, oMWe, oMBe}, {3'b111, 4'hF});
    checkVal("st wdata", oMWData, 32'hDEADBEEF);
    cyc;
    iDReq = 1'b0; iDWe = 1'b0;
    @(negedge iCLK);
    checkVal("st ack", {oDValid, oIValid, oMReq, oBusy}, 4'b1001);
    checkVal("st rdata kept", oDRData, 0);
    cyc;
    @(negedge iCLK);
    checkVal("st done", {oDValid, oBusy}, 0);
    readTxn(1'b1, 32'h10010000, 32'hDEADBEEF, "st rd");

    // Partial store keeps the unselected bytes
    cyc;
    iDReq = 1'b1; iDWe = 1'b1; iDBe = 4'b0011; iDAddr = 32'h10010000; iDWData = 32'h12345678;
    @(negedge iCLK);
    checkVal("pst be", {oDGnt, oMWe, oMBe}, {2'b11, 4'b0011});
    cyc;
    iDReq = 1'b0; iDWe = 1'b0;
    readTxn(1'b1, 32'h10010000, 32'hDEAD5678, "pst rd");

    // Back-to-back fetches
    cyc;
    iIReq = 1'b1; iIAddr = 32'h0;
    @(negedge iCLK);
    checkVal("b2b gnt0", oIGnt, 1);
    cyc;
    iIAddr = 32'h4;
    @(negedge iCLK);
    checkVal("b2b wait1", {oIGnt, oMReq}, 0);
    cyc;
    @(negedge iCLK);
    checkVal("b2b wait2", {oIGnt, oMReq}, 0);
    cyc;
    @(negedge iCLK);
    checkVal("b2b gnt1+valid0", {oIGnt, oIValid, oMReq}, 3'b111);
    checkVal("b2b data0", oIData, 32'h00000013);
    checkVal("b2b maddr1", oMAddr, 32'h4);
    cyc;
    iIReq = 1'b0;
    @(negedge iCLK);
    checkVal("b2b gap", oIValid, 0);
    cyc;
    cyc;
    @(negedge iCLK);
    checkVal("b2b valid1", oIValid, 1);
    checkVal("b2b data1", oIData, 32'h00100113);

    // Data request raised during a fetch's WAIT
    cyc;
    iIReq = 1'b1; iIAddr = 32'h00400000;
    @(negedge iCLK);
    checkVal("late gntI", oIGnt, 1);
    cyc;
    iIReq = 1'b0; iDReq = 1'b1; iDWe = 1'b0; iDBe = 4'hF; iDAddr = 32'h10010040;
    @(negedge iCLK);
    checkVal("late wait1", {oDGnt, oMReq}, 0);
    cyc;
    @(negedge iCLK);
    checkVal("late wait2", {oDGnt, oMReq}, 0);
    cyc;
    @(negedge iCLK);
    checkVal("late resp", {oIValid, oDGnt, oMReq}, 3'b111);
    checkVal("late maddr", oMAddr, 32'h10010040);
    cyc;
    iDReq = 1'b0;
    @(negedge iCLK);
    checkVal("late single", {oMReq, oIValid}, 0);
    cyc;
    cyc;
    @(negedge iCLK);
    checkVal("late dvalid", {oDValid, oIValid}, 2'b10);
    checkVal("late data", oDRData, 32'hCAFEF00D);

    // Reset during a load's WAIT
    cyc;
    iDReq = 1'b1; iDWe = 1'b0; iDBe = 4'hF; iDAddr = 32'h10010000;
    @(negedge iCLK);
    checkVal("rst gnt", oDGnt, 1);
    cyc;
    iDReq = 1'b0;
    #1;
    iRST = 1'b0;
    #1;
    checkVal("rst mid ctrl", {oBusy, oIValid, oDValid, oMReq, oIGnt, oDGnt, oMWe, oMBe}, 0);
    checkVal("rst mid data", {oIData, oDRData, oMAddr}, 0);
    cyc;
    cyc;
    iRST = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge iCLK);
      checkVal("rst no valid", {oDValid, oBusy}, 0);
      cyc;
    end
    readTxn(1'b0, 32'h00000004, 32'h00100113, "post rst");

    // Simultaneous held requests, three rounds
`ifdef ARB_RR_EN
    expWin = '{WIN_D, WIN_I, WIN_D};
`else
    expWin = '{WIN_D, WIN_D, WIN_D};
`endif
    cyc;
    iIReq = 1'b1; iIAddr = 32'h0;
    iDReq = 1'b1; iDWe = 1'b0; iDBe = 4'hF; iDAddr = 32'h10010040;
    rounds = 0;
    for (int n = 0; n < 20 && rounds < 3; n++) begin
      @(negedge iCLK);
      checkVal("arb exclusive", oIGnt & oDGnt, 0);
      if (oDGnt) begin
        winners[rounds] = WIN_D; rounds++;
      end else if (oIGnt) begin
        winners[rounds] = WIN_I; rounds++;
      end
      if (rounds < 3) cyc;
    end
    checkVal("arb rounds", rounds, 3);
    for (int r = 0; r < 3; r++)
      checkVal($sformatf("arb winner %0d", r), winners[r], expWin[r]);
    cyc;
    iIReq = 1'b0; iDReq = 1'b0;
    idle = 1'b0;
    for (int n = 0; n < 10 && !idle; n++) begin
      @(negedge iCLK);
      idle = !oBusy;
      if (!idle) cyc;
    end
    checkVal("arb drain", idle, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
